// File: rtl/multicycle_control_if.sv
// Datapath/memory handshake bundle for the multicycle control unit.
// The master modport is the control unit; the slave modport is the datapath/memory side.
interface multicycle_control_if #(
    parameter int unsigned OPW  = 4,
    parameter int unsigned EOEW = 4
);
    // Inputs to the control unit
    logic [OPW-1:0]  opcode;
    logic [EOEW-1:0] eoe;
    logic            Z;
    logic            mem_ready;

    // Strobes and status from the control unit
    logic [OPW-1:0]  FS;
    logic [1:0]      PS;
    logic            IL;
    logic            MB;
    logic            MD;
    logic            RW;
    logic            MM;
    logic            MW;
    logic            WP;
    logic [2:0]      state_o;
    logic            halted;

    modport master (
        input  opcode, eoe, Z, mem_ready,
        output FS, PS, IL, MB, MD, RW, MM, MW, WP, state_o, halted
    );

    modport slave (
        output opcode, eoe, Z, mem_ready,
        input  FS, PS, IL, MB, MD, RW, MM, MW, WP, state_o, halted
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: FETCH/EXEC/MEM/WB/HALT sequencer with a memory-ready
// handshake, latched opcode/eoe registers and a sticky halt state.
// Special-group sub-opcodes (opcode MSB = 1, low 3 bits):
//   000 LI, 001 LW, 010 SW, 011 BIZ, 100 BNZ, 101 JAL, 110 JMP, 111 JR
module multicycle_control #(
    parameter int unsigned OPW        = 4,
    parameter int unsigned EOEW       = 4,
    parameter int unsigned FETCH_WAIT = 1
) (
    input  logic                clk,
    input  logic                rst,
    multicycle_control_if.master bus
);

    typedef enum logic [2:0] {
        StFetch = 3'd0,
        StExec  = 3'd1,
        StMem   = 3'd2,
        StWb    = 3'd3,
        StHalt  = 3'd4
    } state_e;

    localparam logic [2:0] SpLi  = 3'd0;
    localparam logic [2:0] SpLw  = 3'd1;
    localparam logic [2:0] SpSw  = 3'd2;
    localparam logic [2:0] SpBiz = 3'd3;
    localparam logic [2:0] SpBnz = 3'd4;
    localparam logic [2:0] SpJal = 3'd5;
    localparam logic [2:0] SpJmp = 3'd6;
    localparam logic [2:0] SpJr  = 3'd7;

    localparam logic [1:0] PsHold = 2'b00;
    localparam logic [1:0] PsInc  = 2'b01;
    localparam logic [1:0] PsOff  = 2'b10;
    localparam logic [1:0] PsJmp  = 2'b11;

    state_e          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [EOEW-1:0] eoe_q, eoe_d;

    logic fetch_go;
    logic mid_nz;
    logic eoe_end;

    // Fetch handshake; with FETCH_WAIT=0 memory is assumed to answer in one cycle
    assign fetch_go = (FETCH_WAIT == 0) ? 1'b1 : bus.mem_ready;
    assign eoe_end  = &eoe_q;

    // Special-group opcodes with nonzero middle bits (OPW>4 only) decode as NOP
    always_comb begin
        mid_nz = 1'b0;
        for (int i = 3; i < int'(OPW) - 1; i++) begin
            mid_nz = mid_nz | op_q[i];
        end
    end

    // Next-state, latch-enable and strobe decode
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        eoe_d       = eoe_q;
        bus.FS      = op_q;
        bus.PS      = PsHold;
        bus.IL      = 1'b0;
        bus.MB      = 1'b0;
        bus.MD      = 1'b0;
        bus.RW      = 1'b0;
        bus.MM      = 1'b0;
        bus.MW      = 1'b0;
        bus.WP      = 1'b0;
        bus.halted  = 1'b0;
        bus.state_o = state_q;

        case (state_q)
            StFetch: begin
                bus.MM = 1'b1;
                if (fetch_go) begin
                    bus.IL  = 1'b1;
                    op_d    = bus.opcode;
                    eoe_d   = bus.eoe;
                    state_d = StExec;
                end
            end

            StExec: begin
                state_d = StFetch;
                if (!op_q[OPW-1]) begin
                    bus.RW = 1'b1;
                    bus.PS = PsInc;
                end else if (mid_nz) begin
                    bus.PS = PsInc;
                end else begin
                    case (op_q[2:0])
                        SpLi: begin
                            bus.MB = 1'b1;
                            bus.RW = 1'b1;
                            bus.PS = PsInc;
                        end
                        SpLw, SpSw: state_d = StMem;
                        SpBiz:  bus.PS = bus.Z ? PsOff : PsInc;
                        SpBnz:  bus.PS = bus.Z ? PsInc : PsOff;
                        SpJal: begin
                            bus.RW = 1'b1;
                            bus.WP = 1'b1;
                            bus.PS = PsJmp;
                        end
                        SpJmp:  bus.PS = PsJmp;
                        SpJr: begin
                            if (eoe_end) begin
                                state_d = StHalt;
                            end else begin
                                bus.PS = PsJmp;
                            end
                        end
                        default: bus.PS = PsInc;
                    endcase
                end
            end

            StMem: begin
                // MM stays 0 to address data memory; wait indefinitely for the handshake
                if (op_q[2:0] == SpSw) begin
                    bus.MW = 1'b1;
                    if (bus.mem_ready) begin
                        bus.PS  = PsInc;
                        state_d = StFetch;
                    end
                end else if (op_q[2:0] == SpLw) begin
                    if (bus.mem_ready) begin
                        state_d = StWb;
                    end
                end else begin
                    state_d = StFetch;
                end
            end

            StWb: begin
                bus.MD  = 1'b1;
                bus.RW  = 1'b1;
                bus.PS  = PsInc;
                state_d = StFetch;
            end

            StHalt: begin
                bus.halted = 1'b1;
            end

            default: state_d = StFetch;
        endcase
    end

    // State and instruction-field registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            op_q    <= '0;
            eoe_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            eoe_q   <= eoe_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver expands each instruction into its
// expected per-cycle output trace and queues it; a negedge monitor pops and compares.
module tb_multicycle_control;

    localparam int unsigned OPW  = 4;
    localparam int unsigned EOEW = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_control_if #(.OPW(OPW), .EOEW(EOEW)) bus ();

    multicycle_control #(
        .OPW       (OPW),
        .EOEW      (EOEW),
        .FETCH_WAIT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Expected entry: {check_enable, state[2:0], FS[3:0], PS[1:0], IL, MB, MD, RW, MM, MW, WP, halted}
    logic [17:0] exp_q[$];
    string       name_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [3:0]  cur_fs;

    logic [17:0] mon_e;
    string       mon_n;
    logic [16:0] mon_obs;

    // Monitor: one DUT output vector per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_n   = name_q.pop_front();
            mon_obs = {bus.state_o, bus.FS, bus.PS, bus.IL, bus.MB, bus.MD, bus.RW,
                       bus.MM, bus.MW, bus.WP, bus.halted};
            if (mon_e[17]) begin
                checks++;
                if (mon_obs !== mon_e[16:0]) begin
                    errors++;
                    $display("FAIL %s t=%0t got st/fs/ps/il,mb,md,rw,mm,mw,wp,hl=%b exp=%b",
                             mon_n, $time, mon_obs, mon_e[16:0]);
                end
            end
        end
    end

    // Expected output vector for one cycle; FS always reflects the latched opcode
    function automatic logic [16:0] o(input logic [2:0] st, input logic [1:0] ps,
                                      input logic il, input logic mb, input logic md,
                                      input logic rw, input logic mm, input logic mw,
                                      input logic wp);
        return {st, cur_fs, ps, il, mb, md, rw, mm, mw, wp, (st == 3'd4)};
    endfunction

    task automatic step(input logic r, input logic [3:0] op, input logic [3:0] e,
                        input logic z, input logic mr, input logic chk,
                        input logic [16:0] v, input string n);
        rst           = r;
        bus.opcode    = op;
        bus.eoe       = e;
        bus.Z         = z;
        bus.mem_ready = mr;
        exp_q.push_back({chk, v});
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] r4();
        return 4'($urandom);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    // Fetch phase: fw stalled cycles, then the accepting cycle
    task automatic do_fetch(input logic [3:0] op, input logic [3:0] e, input int fw,
                            input string n);
        for (int i = 0; i < fw; i++) begin
            step(1'b0, r4(), r4(), r1(), 1'b0, 1'b1, o(3'd0, 2'b00, 0, 0, 0, 0, 1, 0, 0), n);
        end
        step(1'b0, op, e, r1(), 1'b1, 1'b1, o(3'd0, 2'b00, 1, 0, 0, 0, 1, 0, 0), n);
        cur_fs = op;
    endtask

    // One full instruction: fetch, execute, optional memory/writeback, optional halt+reset
    task automatic run_instr(input logic [3:0] op, input logic [3:0] e, input logic z,
                             input int fw, input int mw, input string n);
        logic [16:0] v;
        logic        is_mem;
        logic        halt;
        is_mem = op[3] && (op[2:0] == 3'd1 || op[2:0] == 3'd2);
        halt   = op[3] && (op[2:0] == 3'd7) && (e == 4'hF);
        do_fetch(op, e, fw, n);
        if (!op[3]) begin
            v = o(3'd1, 2'b01, 0, 0, 0, 1, 0, 0, 0);
        end else begin
            case (op[2:0])
                3'd0: v = o(3'd1, 2'b01, 0, 1, 0, 1, 0, 0, 0);
                3'd1, 3'd2: v = o(3'd1, 2'b00, 0, 0, 0, 0, 0, 0, 0);
                3'd3: v = o(3'd1, z ? 2'b10 : 2'b01, 0, 0, 0, 0, 0, 0, 0);
                3'd4: v = o(3'd1, z ? 2'b01 : 2'b10, 0, 0, 0, 0, 0, 0, 0);
                3'd5: v = o(3'd1, 2'b11, 0, 0, 0, 1, 0, 0, 1);
                3'd6: v = o(3'd1, 2'b11, 0, 0, 0, 0, 0, 0, 0);
                default: v = o(3'd1, halt ? 2'b00 : 2'b11, 0, 0, 0, 0, 0, 0, 0);
            endcase
        end
        step(1'b0, r4(), r4(), z, r1(), 1'b1, v, n);
        if (is_mem) begin
            for (int i = 0; i < mw; i++) begin
                step(1'b0, r4(), r4(), r1(), 1'b0, 1'b1,
                     o(3'd2, 2'b00, 0, 0, 0, 0, 0, op[1], 0), n);
            end
            if (op[1]) begin
                step(1'b0, r4(), r4(), r1(), 1'b1, 1'b1,
                     o(3'd2, 2'b01, 0, 0, 0, 0, 0, 1, 0), n);
            end else begin
                step(1'b0, r4(), r4(), r1(), 1'b1, 1'b1,
                     o(3'd2, 2'b00, 0, 0, 0, 0, 0, 0, 0), n);
                step(1'b0, r4(), r4(), r1(), r1(), 1'b1,
                     o(3'd3, 2'b01, 0, 0, 1, 1, 0, 0, 0), n);
            end
        end
        if (halt) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b0, r4(), r4(), r1(), i[0], 1'b1,
                     o(3'd4, 2'b00, 0, 0, 0, 0, 0, 0, 0), {n, "_halt"});
            end
            step(1'b1, r4(), r4(), r1(), r1(), 1'b1,
                 o(3'd4, 2'b00, 0, 0, 0, 0, 0, 0, 0), {n, "_halt_rst"});
            cur_fs = 4'h0;
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.opcode    = '0;
        bus.eoe       = '0;
        bus.Z         = 1'b0;
        bus.mem_ready = 1'b0;
        cur_fs        = 4'h0;
        @(posedge clk);
        #1;
        step(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, '0, "reset");
        step(1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, '0, "reset");

        run_instr(4'b0000, 4'h0, 1'b0, 0, 0, "add_after_reset");
        run_instr(4'b0110, 4'h3, 1'b1, 3, 0, "fetch_stall");
        run_instr(4'b1001, 4'h0, 1'b0, 0, 2, "lw_wait2");
        run_instr(4'b1010, 4'h0, 1'b0, 0, 0, "sw");
        run_instr(4'b1000, 4'h0, 1'b0, 0, 0, "li");
        run_instr(4'b1011, 4'h0, 1'b1, 0, 0, "biz_z1");
        run_instr(4'b1011, 4'h0, 1'b0, 0, 0, "biz_z0");
        run_instr(4'b1100, 4'h0, 1'b1, 0, 0, "bnz_z1");
        run_instr(4'b1100, 4'h0, 1'b0, 0, 0, "bnz_z0");
        run_instr(4'b1101, 4'h0, 1'b0, 0, 0, "jal");
        run_instr(4'b1110, 4'h0, 1'b0, 0, 0, "jmp");
        run_instr(4'b1111, 4'h7, 1'b0, 0, 0, "jr_noend");
        run_instr(4'b1111, 4'hF, 1'b0, 1, 0, "jr_halt");
        run_instr(4'b0101, 4'h0, 1'b0, 0, 0, "alu_after_halt");

        // Reset asserted while an LW waits in MEM
        do_fetch(4'b1001, 4'h2, 0, "lw_rst");
        step(1'b0, r4(), r4(), r1(), 1'b1, 1'b1, o(3'd1, 2'b00, 0, 0, 0, 0, 0, 0, 0), "lw_rst");
        step(1'b0, r4(), r4(), r1(), 1'b0, 1'b1, o(3'd2, 2'b00, 0, 0, 0, 0, 0, 0, 0), "lw_rst");
        step(1'b1, r4(), r4(), r1(), 1'b0, 1'b1, o(3'd2, 2'b00, 0, 0, 0, 0, 0, 0, 0), "lw_rst");
        cur_fs = 4'h0;
        step(1'b0, r4(), r4(), r1(), 1'b0, 1'b1, o(3'd0, 2'b00, 0, 0, 0, 0, 1, 0, 0),
             "lw_rst_fetch");

        for (int k = 0; k < 300; k++) begin
            run_instr(r4(), r4(), r1(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                      "random");
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
